// File: rtl/pru_port_arb.sv
// rtl/pru_port_arb.sv - weighted round-robin arbiter feeding the PRU ingress FIFO write port
module pru_port_arb #(
    parameter int N  = 16,
    parameter int PW = 128,
    parameter int WW = 4
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic [N-1:0]    portIf_arb_vld,
    input  logic [N*PW-1:0] portIf_arb_pkt,
    output logic [N-1:0]    arb_portIf_ack,
    input  logic [N-1:0]    cfg_en,
    input  logic [N*WW-1:0] cfg_weight,
    input  logic            fifo_arb_full,
    output logic            arb_fifo_wr,
    output logic [PW-1:0]   arb_fifo_pkt,
    output logic [3:0]      arb_grantIdx,
    output logic            arb_busy
);

    typedef enum logic {SCAN, BURST} state_t;

    state_t          state, state_n;
    logic [3:0]      ptr, ptr_n, owner, owner_n;
    logic [WW-1:0]   cnt, cnt_n;
    logic            out_vld;
    logic [PW-1:0]   out_pkt;

    logic [N-1:0]    elig;
    logic            scan_hit, cand_vld, accept;
    logic [3:0]      scan_idx, cand;
    logic [WW-1:0]   cand_weight;

    assign elig = portIf_arb_vld & cfg_en;

    // Walk offsets from high to low so the nearest eligible port after ptr wins.
    always_comb begin
        logic [3:0] idx;
        idx      = '0;
        scan_hit = 1'b0;
        scan_idx = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ptr + 4'(k);
            if (elig[idx]) begin
                scan_hit = 1'b1;
                scan_idx = idx;
            end
        end
    end

    always_comb begin
        cand     = scan_idx;
        cand_vld = scan_hit;
        if (state == BURST) begin
            cand     = owner;
            cand_vld = elig[owner];
        end
    end

    assign accept      = cand_vld & (~out_vld | ~fifo_arb_full);
    assign cand_weight = cfg_weight[32'(cand)*WW +: WW];

    always_comb begin
        arb_portIf_ack = '0;
        if (accept && !iRst)
            arb_portIf_ack[cand] = 1'b1;
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        cnt_n   = cnt;
        case (state)
            SCAN: begin
                if (accept) begin
                    if (cand_weight == '0) begin
                        ptr_n = cand + 4'd1;
                    end else begin
                        owner_n = cand;
                        cnt_n   = cand_weight;
                        state_n = BURST;
                    end
                end
            end
            BURST: begin
                // Owner gone: give up the turn, costing one idle cycle.
                if (!elig[owner]) begin
                    ptr_n   = owner + 4'd1;
                    state_n = SCAN;
                end else if (accept) begin
                    cnt_n = cnt - 1'b1;
                    if (cnt == WW'(1)) begin
                        ptr_n   = owner + 4'd1;
                        state_n = SCAN;
                    end
                end
            end
            default: state_n = SCAN;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state        <= SCAN;
            ptr          <= '0;
            owner        <= '0;
            cnt          <= '0;
            out_vld      <= 1'b0;
            out_pkt      <= '0;
            arb_grantIdx <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
            cnt   <= cnt_n;
            if (accept) begin
                out_pkt      <= portIf_arb_pkt[32'(cand)*PW +: PW];
                out_vld      <= 1'b1;
                arb_grantIdx <= cand;
            end else if (arb_fifo_wr) begin
                out_vld <= 1'b0;
            end
        end
    end

    assign arb_fifo_wr  = out_vld & ~fifo_arb_full & ~iRst;
    assign arb_fifo_pkt = out_pkt;
    assign arb_busy     = (state == BURST);

endmodule

// File: tb/tb_pru_port_arb.sv
// tb/tb_pru_port_arb.sv - scoreboard bench for pru_port_arb with a turn-based reference model
module tb_pru_port_arb;
    localparam int N  = 16;
    localparam int PW = 128;
    localparam int WW = 4;

    logic            iClk = 1'b0;
    logic            iRst;
    logic [N-1:0]    vld, en, ack;
    logic [N*PW-1:0] pkt_bus;
    logic [N*WW-1:0] w_bus;
    logic            full, wr, busy;
    logic [PW-1:0]   fifo_pkt;
    logic [3:0]      gidx;

    logic [PW-1:0]   pkt_r [N];
    logic [WW-1:0]   w_r   [N];

    int checks = 0;
    int failures = 0;

    // Reference model: a turn is (owner, grants left); -1 means free scanning.
    int              m_turn, m_left, m_next;
    bit              m_out;
    logic [3:0]      m_gidx;
    logic [PW-1:0]   expq[$];
    int              cyc_log[$];
    int              ack_cnt, wr_cnt;
    logic [N-1:0]    last_ack;
    bit              prev_rst;

    always #5 iClk = ~iClk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            pkt_bus[i*PW +: PW] = pkt_r[i];
            w_bus[i*WW +: WW]   = w_r[i];
        end
    end

    pru_port_arb #(.N(N), .PW(PW), .WW(WW)) dut (
        .iClk(iClk), .iRst(iRst),
        .portIf_arb_vld(vld), .portIf_arb_pkt(pkt_bus), .arb_portIf_ack(ack),
        .cfg_en(en), .cfg_weight(w_bus), .fifo_arb_full(full),
        .arb_fifo_wr(wr), .arb_fifo_pkt(fifo_pkt),
        .arb_grantIdx(gidx), .arb_busy(busy)
    );

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] new_pkt();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_turn = -1; m_left = 0; m_next = 0; m_out = 0; m_gidx = '0;
        expq.delete();
    endtask

    task automatic cyc(input bit rst, input logic [N-1:0] v, input bit f);
        int cand, dut_idx;
        bit acc, abort;
        logic [N-1:0] elig, exp_ack, seen;
        iRst = rst; vld = v; full = f;
        @(negedge iClk);
        seen = ack;
        if (rst) begin
            chk("rst_ack", ack, '0);
            chk("rst_wr", wr, 1'b0);
            if (prev_rst) begin
                chk("rst_busy", busy, 1'b0);
                chk("rst_grant_idx", gidx, 4'd0);
            end
            model_reset();
        end else begin
            elig  = v & en;
            cand  = -1;
            abort = 0;
            if (m_turn >= 0) begin
                if (elig[m_turn]) cand = m_turn;
                else abort = 1;
            end else begin
                for (int k = 0; k < N; k++)
                    if (cand < 0 && elig[(m_next + k) % N]) cand = (m_next + k) % N;
            end
            acc = (cand >= 0) && (!m_out || !f);
            exp_ack = '0;
            if (acc) exp_ack[cand] = 1'b1;
            chk("ack", ack, exp_ack);
            chk("busy", busy, m_turn >= 0);
            chk("grant_idx", gidx, m_gidx);
            chk("wr", wr, m_out && !f);
            dut_idx = -1;
            for (int k = 0; k < N; k++) if (ack[k]) dut_idx = k;
            cyc_log.push_back(dut_idx);
            if (ack != '0) ack_cnt++;
            if (wr) wr_cnt++;
            if (abort) begin
                m_next = (m_turn + 1) % N;
                m_turn = -1;
            end else if (acc) begin
                if (m_turn < 0) begin
                    if (w_r[cand] == 0) m_next = (cand + 1) % N;
                    else begin m_turn = cand; m_left = int'(w_r[cand]); end
                end else begin
                    m_left--;
                    if (m_left == 0) begin m_next = (m_turn + 1) % N; m_turn = -1; end
                end
            end
            if (acc) begin
                m_out  = 1;
                m_gidx = 4'(cand);
                expq.push_back(pkt_r[cand]);
            end else if (m_out && !f) begin
                m_out = 0;
            end
        end
        prev_rst = rst;
        last_ack = rst ? '0 : seen;
        @(posedge iClk); #1;
        for (int i = 0; i < N; i++) if (last_ack[i]) pkt_r[i] = new_pkt();
    endtask

    task automatic chk_log(input string name, input int e[$]);
        chk({name, "_len"}, cyc_log.size(), e.size());
        for (int i = 0; i < e.size() && i < cyc_log.size(); i++)
            chk(name, cyc_log[i], e[i]);
    endtask

    always @(negedge iClk) begin
        if (iRst === 1'b0 && wr === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL fifo_pkt: write of %0h with nothing expected at %0t", fifo_pkt, $time);
            end else begin
                chk("fifo_pkt", fifo_pkt, expq.pop_front());
            end
        end
    end

    initial begin
        int e[$];
        logic [N-1:0] req;
        iRst = 1'b1; vld = '0; full = 1'b0; en = '1; prev_rst = 1'b1;
        for (int i = 0; i < N; i++) begin pkt_r[i] = new_pkt(); w_r[i] = '0; end
        model_reset();
        @(posedge iClk); #1;

        repeat (3) cyc(1, '1, 0);
        cyc_log.delete();
        repeat (4) cyc(0, '1, 0);
        e = '{0, 1, 2, 3}; chk_log("after_reset", e);

        cyc(1, '0, 0); cyc_log.delete();
        repeat (6) cyc(0, 16'h8021, 0);
        e = '{0, 5, 15, 0, 5, 15}; chk_log("plain_rr", e);

        w_r[2] = 4'd3;
        cyc(1, '0, 0); cyc_log.delete();
        repeat (10) cyc(0, 16'h0084, 0);
        e = '{2, 2, 2, 2, 7, 2, 2, 2, 2, 7}; chk_log("weighted", e);
        w_r[2] = '0;

        cyc(1, '0, 0);
        cyc(0, 16'h0002, 0);
        cyc(0, 16'h0000, 0);
        ack_cnt = 0; wr_cnt = 0;
        repeat (5) cyc(0, 16'h0002, 1);
        chk("bp_acks_during_full", ack_cnt, 1);
        chk("bp_writes_during_full", wr_cnt, 0);
        wr_cnt = 0;
        cyc(0, 16'h0002, 0);
        chk("bp_release_write", wr_cnt, 1);

        cyc(1, '0, 0); cyc_log.delete();
        cyc(0, 16'h4000, 0);
        repeat (2) cyc(0, 16'h8008, 0);
        e = '{14, 15, 3}; chk_log("wrap", e);

        w_r[4] = 4'd5;
        cyc(1, '0, 0); cyc_log.delete();
        repeat (2) cyc(0, 16'h0210, 0);
        repeat (2) cyc(0, 16'h0200, 0);
        e = '{4, 4, -1, 9}; chk_log("burst_abort", e);
        en[9] = 1'b0;
        cyc(1, '0, 0); cyc_log.delete();
        repeat (2) cyc(0, 16'h0210, 0);
        repeat (2) cyc(0, 16'h0200, 0);
        e = '{4, 4, -1, -1}; chk_log("burst_abort_dis", e);
        en = '1; w_r[4] = '0;

        req = '0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) begin
                for (int i = 0; i < N; i++) begin
                    w_r[i] = 4'($urandom_range(0, 3));
                    en[i]  = ($urandom_range(0, 7) != 0);
                end
            end
            if ($urandom_range(0, 499) == 0) begin
                cyc(1, req, 0);
            end else begin
                cyc(0, req, $urandom_range(0, 3) == 0);
            end
            for (int i = 0; i < N; i++) begin
                if (last_ack[i]) req[i] = $urandom_range(0, 1);
                else if (!req[i]) req[i] = ($urandom_range(0, 2) == 0);
            end
        end
        repeat (3) cyc(0, '0, 0);
        chk("queue_drained", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
